layer_input_streamer: RTL and testbench
=======================================

Name: layer_input_streamer

Overview:
- Parametrised successor to the single-lane input serializer that feeds neuron MAC pipelines.
- Captures a full input vector through a valid/ready handshake, then streams it out LANES words per beat with valid/ready backpressure.
- Each beat carries an input index, a lane mask and a last flag, so one or several neuron FSMs can consume it.
- Sits between the input/activation buffer of one layer and the neuron array of the next.

Parameters:
NUM_INPUTS, 16, words per input vector (>=1)
DATA_WIDTH, 8, bits per word
LANES, 1, words emitted per beat (1..NUM_INPUTS)
BEATS, (NUM_INPUTS+LANES-1)/LANES, derived, beats per vector (+1 when bias beat enabled)
COUNTER_WIDTH, $clog2(NUM_INPUTS+1), derived, width of out_index
BIAS_VALUE, 8'h01 (sized DATA_WIDTH), word emitted in bias beat (used only with the optional feature)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  in_data holds a vector
in_ready  out  1  block can capture a vector
in_data  in  DATA_WIDTH*NUM_INPUTS  word i at bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
out_valid  out  1  beat present
out_ready  in  1  consumer accepts the beat
out_data  out  DATA_WIDTH*LANES  lane j holds word beat*LANES+j
out_mask  out  LANES  lane j holds a real word
out_index  out  COUNTER_WIDTH  index of the word in lane 0
out_last  out  1  final beat of the vector
busy  out  1  high while not IDLE
done  out  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset (synchronous, active-high, on clk):
  - state=IDLE, beat counter=0, capture register=0, done=0.
  - Outputs: out_valid=0, out_data=0, out_mask=0, out_index=0, out_last=0, busy=0, in_ready=1.
- FSM states: IDLE, STREAM, BIAS (BIAS exists only with the macro).
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid, capture in_data into the register, beat=0, next state STREAM.
- STREAM:
  - in_ready=0, out_valid=1.
  - out_data, out_mask, out_index and out_last are registered functions of beat and the captured register.
  - On out_valid&&out_ready:
    - final data beat, macro off: go to IDLE and pulse done next cycle.
    - final data beat, macro on: go to BIAS.
    - otherwise: beat+1.
- Latency: first out_valid one cycle after the in_valid&&in_ready capture edge. Full throughput is one beat per cycle with out_ready held high.
- Per-vector period: BEATS+1 cycles. A new vector is not accepted until the FSM returns to IDLE.
- Backpressure: while out_valid&&!out_ready, all out_* signals hold stable and the beat does not advance.
- Partial final beat (NUM_INPUTS%LANES != 0):
  - unused lanes carry 0 with mask bit 0.
  - valid lanes are the low lanes.
- out_index = beat*LANES and never exceeds NUM_INPUTS-1 in STREAM.
- out_last=1 only on the final beat of the vector, counting the bias beat when enabled.
- Reset mid-stream: the vector is discarded, no done pulse, and the block returns to IDLE on the next edge.
- in_valid outside IDLE is ignored and the source must hold it.
- done fires exactly once per vector. busy=1 in STREAM and BIAS.

Optional Feature:
- Macro LAYER_STREAMER_BIAS_EN.
- Defined:
  - after the last data beat, a BIAS beat is emitted: lane 0=BIAS_VALUE, other lanes 0, out_mask=1 (lane 0 only), out_index=NUM_INPUTS, out_last=1.
  - The data beat preceding it has out_last=0.
  - done pulses after the bias beat is accepted.
- Undefined: there is no BIAS state, and the last data beat asserts out_last.

Decomposition:
- Package nn_stream_pkg:
  - state enum (IDLE, STREAM, BIAS)
  - function beats_for(num, lanes)
  - default DATA_WIDTH localparam
- Sub-module lane_window_mux: combinational lane/mask extraction from the captured register given beat, LANES and NUM_INPUTS. It is reused by the output serializer.

Test Plan:
- N=16, L=1, word i=i+1, out_ready=1 -> 16 beats with data 1..16 and index 0..15, out_last on index 15, done one cycle after, in_ready back high.
- N=16, L=4 -> 4 beats, index 0,4,8,12, mask 4'b1111, beat 2 out_data={12,11,10,9}.
- N=10, L=4 -> 3 beats, final beat index 8, mask 4'b0011, lanes 2-3 zero.
- N=16, L=1, out_ready low on beat 5 for 3 cycles -> out_data=6 and index=5 held stable, no skipped or repeated word.
- Reset asserted during beat 7 -> next cycle out_valid=0, busy=0, in_ready=1, no done. A new vector then streams from index 0.
- LAYER_STREAMER_BIAS_EN, N=16, L=4 -> 5 beats, beat 4 lane0=BIAS_VALUE, index=16, mask 4'b0001, out_last only on beat 4.

Source files
------------

// File: rtl/nn_stream_pkg.sv
// Shared types and helpers for the layer input streaming path.
// Optional macro LAYER_STREAMER_BIAS_EN adds the BIAS state to the FSM encoding.
package nn_stream_pkg;

  localparam int NN_DATA_WIDTH = 8;

`ifdef LAYER_STREAMER_BIAS_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    BIAS   = 2'd2
  } stream_state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1
  } stream_state_t;
`endif

  // Number of beats needed to move num words when lanes words go out per beat.
  function automatic int beats_for(input int num, input int lanes);
    return (num + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/lane_window_mux.sv
// Picks the LANES-word window for a given beat out of a captured vector.
// Lanes past the end of the vector read as zero with their mask bit cleared.
module lane_window_mux #(
  parameter int NUM_INPUTS = 16,
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 1,
  parameter int BEAT_W     = 4
) (
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] vec,
  input  logic [BEAT_W-1:0]                beat,
  output logic [LANES*DATA_WIDTH-1:0]      data,
  output logic [LANES-1:0]                 mask
);

  // Lane j carries word beat*LANES+j when that word exists in the vector.
  always_comb begin
    data = '0;
    mask = '0;
    for (int j = 0; j < LANES; j++) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if ((int'(beat) * LANES + j) == i) begin
          data[j*DATA_WIDTH +: DATA_WIDTH] = vec[i*DATA_WIDTH +: DATA_WIDTH];
          mask[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/layer_input_streamer.sv
// Captures one input vector and streams it out LANES words per beat with
// valid/ready backpressure, tagging each beat with index, lane mask and last.
// Optional macro LAYER_STREAMER_BIAS_EN appends a bias beat after the data.
module layer_input_streamer
  import nn_stream_pkg::*;
#(
  parameter int NUM_INPUTS = 16,
  parameter int DATA_WIDTH = NN_DATA_WIDTH,
  parameter int LANES      = 1,
  parameter logic [DATA_WIDTH-1:0] BIAS_VALUE = DATA_WIDTH'(1),
  localparam int COUNTER_WIDTH = $clog2(NUM_INPUTS + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH*NUM_INPUTS-1:0] in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH*LANES-1:0]     out_data,
  output logic [LANES-1:0]                out_mask,
  output logic [COUNTER_WIDTH-1:0]        out_index,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done
);

  localparam int BEATS  = beats_for(NUM_INPUTS, LANES);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  stream_state_t                   state, state_next;
  logic [BEAT_W-1:0]               beat, beat_next;
  logic [DATA_WIDTH*NUM_INPUTS-1:0] capture;
  logic                            capture_en;
  logic                            done_next;
  logic                            last_data_beat;
  logic [DATA_WIDTH*LANES-1:0]     lane_data;
  logic [LANES-1:0]                lane_mask;

  assign last_data_beat = (beat == BEAT_W'(BEATS - 1));

  lane_window_mux #(
    .NUM_INPUTS (NUM_INPUTS),
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES),
    .BEAT_W     (BEAT_W)
  ) u_window (
    .vec  (capture),
    .beat (beat),
    .data (lane_data),
    .mask (lane_mask)
  );

  // State, beat counter, captured vector and done pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      beat    <= '0;
      capture <= '0;
      done    <= 1'b0;
    end else begin
      state <= state_next;
      beat  <= beat_next;
      done  <= done_next;
      if (capture_en) begin
        capture <= in_data;
      end
    end
  end

  // Next-state logic: capture in IDLE, advance a beat on each accepted transfer.
  always_comb begin
    state_next = state;
    beat_next  = beat;
    capture_en = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          capture_en = 1'b1;
          beat_next  = '0;
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (last_data_beat) begin
`ifdef LAYER_STREAMER_BIAS_EN
            state_next = BIAS;
`else
            state_next = IDLE;
            done_next  = 1'b1;
`endif
          end else begin
            beat_next = beat + BEAT_W'(1);
          end
        end
      end
`ifdef LAYER_STREAMER_BIAS_EN
      BIAS: begin
        if (out_ready) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Beat outputs derived from the registered state, beat and captured vector.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_mask  = '0;
    out_index = '0;
    out_last  = 1'b0;
    case (state)
      STREAM: begin
        out_valid = 1'b1;
        out_data  = lane_data;
        out_mask  = lane_mask;
        out_index = COUNTER_WIDTH'(int'(beat) * LANES);
`ifdef LAYER_STREAMER_BIAS_EN
        out_last  = 1'b0;
`else
        out_last  = last_data_beat;
`endif
      end
`ifdef LAYER_STREAMER_BIAS_EN
      BIAS: begin
        out_valid                  = 1'b1;
        out_data[DATA_WIDTH-1:0]   = BIAS_VALUE;
        out_mask[0]                = 1'b1;
        out_index                  = COUNTER_WIDTH'(NUM_INPUTS);
        out_last                   = 1'b1;
      end
`endif
      default: begin
      end
    endcase
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_layer_input_streamer.sv
// Directed table-driven bench for layer_input_streamer in three shapes:
// N=16/L=1, N=16/L=4 and N=10/L=4. Honours LAYER_STREAMER_BIAS_EN.
module tb_layer_input_streamer;

  localparam int DW = 8;
`ifdef LAYER_STREAMER_BIAS_EN
  localparam bit BIAS_ON = 1'b1;
`else
  localparam bit BIAS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic out_ready;

  logic           iv_a, ir_a, ov_a, ol_a, bz_a, dn_a;
  logic [16*DW-1:0] id_a;
  logic [DW-1:0]  od_a;
  logic [0:0]     om_a;
  logic [4:0]     oi_a;

  logic           iv_b, ir_b, ov_b, ol_b, bz_b, dn_b;
  logic [16*DW-1:0] id_b;
  logic [4*DW-1:0] od_b;
  logic [3:0]     om_b;
  logic [4:0]     oi_b;

  logic           iv_c, ir_c, ov_c, ol_c, bz_c, dn_c;
  logic [10*DW-1:0] id_c;
  logic [4*DW-1:0] od_c;
  logic [3:0]     om_c;
  logic [3:0]     oi_c;

  logic [16*DW-1:0] pat16;
  logic [10*DW-1:0] pat10;

  int assertions = 0;
  int failures   = 0;

  typedef struct {
    int          dut;
    logic        ready;
    logic        ivalid;
    logic        scramble;
    logic        valid;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [4:0]  index;
    logic        last;
    logic        done;
    logic        busy;
    logic        iready;
  } vec_t;

  vec_t tbl[$];

  layer_input_streamer #(.NUM_INPUTS(16), .DATA_WIDTH(DW), .LANES(1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .out_mask(om_a),
    .out_index(oi_a), .out_last(ol_a), .busy(bz_a), .done(dn_a)
  );

  layer_input_streamer #(.NUM_INPUTS(16), .DATA_WIDTH(DW), .LANES(4)) dut_b (
    .clk(clk), .reset(reset), .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b),
    .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .out_mask(om_b),
    .out_index(oi_b), .out_last(ol_b), .busy(bz_b), .done(dn_b)
  );

  layer_input_streamer #(.NUM_INPUTS(10), .DATA_WIDTH(DW), .LANES(4)) dut_c (
    .clk(clk), .reset(reset), .in_valid(iv_c), .in_ready(ir_c), .in_data(id_c),
    .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c), .out_mask(om_c),
    .out_index(oi_c), .out_last(ol_c), .busy(bz_c), .done(dn_c)
  );

  task automatic checkField(input string name, input int n, input int d,
                            input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s vec %0d dut %0d: got %0h expected %0h", name, n, d, act, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v, input int n);
    logic [31:0] ad;
    logic [3:0]  am;
    logic [4:0]  ai;
    logic        av, al, adn, ab, ar;
    case (v.dut)
      0: begin
        av = ov_a; ad = 32'(od_a); am = 4'(om_a); ai = oi_a;
        al = ol_a; adn = dn_a; ab = bz_a; ar = ir_a;
      end
      1: begin
        av = ov_b; ad = od_b; am = om_b; ai = oi_b;
        al = ol_b; adn = dn_b; ab = bz_b; ar = ir_b;
      end
      default: begin
        av = ov_c; ad = od_c; am = om_c; ai = 5'(oi_c);
        al = ol_c; adn = dn_c; ab = bz_c; ar = ir_c;
      end
    endcase
    checkField("out_valid", n, v.dut, 32'(av),  32'(v.valid));
    checkField("out_data",  n, v.dut, ad,       v.data);
    checkField("out_mask",  n, v.dut, 32'(am),  32'(v.mask));
    checkField("out_index", n, v.dut, 32'(ai),  32'(v.index));
    checkField("out_last",  n, v.dut, 32'(al),  32'(v.last));
    checkField("done",      n, v.dut, 32'(adn), 32'(v.done));
    checkField("busy",      n, v.dut, 32'(ab),  32'(v.busy));
    checkField("in_ready",  n, v.dut, 32'(ar),  32'(v.iready));
  endtask

  // Check the outputs of the current cycle, then drive this record's inputs across one edge.
  task automatic applyStimulus(input vec_t v, input int n);
    checkOutput(v, n);
    out_ready = v.ready;
    case (v.dut)
      0: begin iv_a = v.ivalid; id_a = v.scramble ? ~pat16 : pat16; end
      1: begin iv_b = v.ivalid; id_b = v.scramble ? ~pat16 : pat16; end
      default: begin iv_c = v.ivalid; id_c = v.scramble ? ~pat10 : pat10; end
    endcase
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t idleRec(input int d, input logic iv, input logic dn);
    vec_t r;
    r.dut = d; r.ready = 1'b1; r.ivalid = iv; r.scramble = 1'b0;
    r.valid = 1'b0; r.data = '0; r.mask = '0; r.index = '0; r.last = 1'b0;
    r.done = dn; r.busy = 1'b0; r.iready = 1'b1;
    return r;
  endfunction

  // Expected beat sequence for one vector where word w holds w+1.
  task automatic buildStream(input int d, input int n, input int lanes,
                             input int stall_beat, input int stall_len);
    vec_t r;
    int   nb;
    int   w;
    nb = (n + lanes - 1) / lanes;
    tbl.delete();
    tbl.push_back(idleRec(d, 1'b1, 1'b0));
    for (int b = 0; b < nb; b++) begin
      r = idleRec(d, 1'b0, 1'b0);
      r.valid = 1'b1; r.busy = 1'b1; r.iready = 1'b0;
      r.index = 5'(b * lanes);
      r.last = (b == nb - 1) && !BIAS_ON;
      r.scramble = (b >= 1);
      r.ivalid = (b >= 2) && (b <= 4);
      for (int j = 0; j < lanes; j++) begin
        w = b * lanes + j;
        if (w < n) begin
          r.data[j*8 +: 8] = 8'(w + 1);
          r.mask[j] = 1'b1;
        end
      end
      if (b == stall_beat) begin
        r.ready = 1'b0;
        for (int s = 0; s < stall_len; s++) tbl.push_back(r);
        r.ready = 1'b1;
      end
      tbl.push_back(r);
    end
    if (BIAS_ON) begin
      r = idleRec(d, 1'b0, 1'b0);
      r.valid = 1'b1; r.busy = 1'b1; r.iready = 1'b0;
      r.data = 32'h0000_0001; r.mask = 4'b0001; r.index = 5'(n); r.last = 1'b1;
      tbl.push_back(r);
    end
    tbl.push_back(idleRec(d, 1'b0, 1'b1));
    tbl.push_back(idleRec(d, 1'b0, 1'b0));
  endtask

  task automatic runTable(input int limit);
    for (int k = 0; k < tbl.size() && k < limit; k++) begin
      applyStimulus(tbl[k], k);
    end
    iv_a = 1'b0; iv_b = 1'b0; iv_c = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) pat16[i*8 +: 8] = 8'(i + 1);
    for (int i = 0; i < 10; i++) pat10[i*8 +: 8] = 8'(i + 1);
    id_a = pat16; id_b = pat16; id_c = pat10;
    iv_a = 1'b0; iv_b = 1'b0; iv_c = 1'b0;
    out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput(idleRec(0, 1'b0, 1'b0), 1000);
    checkOutput(idleRec(1, 1'b0, 1'b0), 1001);
    checkOutput(idleRec(2, 1'b0, 1'b0), 1002);
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] N=16 L=1 full throughput");
    buildStream(0, 16, 1, -1, 0);
    runTable(1000);

    $display("[TB] N=16 L=4");
    buildStream(1, 16, 4, -1, 0);
    runTable(1000);

    $display("[TB] N=10 L=4 partial final beat, stall on beat 1");
    buildStream(2, 10, 4, 1, 2);
    runTable(1000);

    $display("[TB] N=16 L=1 backpressure on beat 5");
    buildStream(0, 16, 1, 5, 3);
    runTable(1000);

    $display("[TB] N=16 L=1 reset during beat 7");
    buildStream(0, 16, 1, -1, 0);
    runTable(8);
    checkField("pre_reset_index", 2000, 0, 32'(oi_a), 32'd7);
    checkField("pre_reset_data",  2000, 0, 32'(od_a), 32'd8);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkField("rst_out_valid", 2001, 0, 32'(ov_a), 32'd0);
    checkField("rst_busy",      2001, 0, 32'(bz_a), 32'd0);
    checkField("rst_in_ready",  2001, 0, 32'(ir_a), 32'd1);
    checkField("rst_done",      2001, 0, 32'(dn_a), 32'd0);
    @(posedge clk);
    #1;
    checkField("rst_done_late", 2002, 0, 32'(dn_a), 32'd0);
    checkField("rst_idle_valid", 2002, 0, 32'(ov_a), 32'd0);
    buildStream(0, 16, 1, -1, 0);
    runTable(1000);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
